// File: rtl/vga_coord_fetch.sv
// ---------------------------------------------------------------------------
// vga_coord_fetch
//
// Shares the single data-memory read port between the CPU and the VGA
// sprite-coordinate loader. Once per frame, on the first blanking line,
// NUM_WORDS coordinate words are read from COORD_BASE upward and presented
// on data_from_mem_vga, tagged with their index+1 on vga_counter. The
// sprite registers downstream therefore only change during vertical
// blanking. The CPU owns the port whenever the loader is not issuing.
//
// Ports
//   clk_25MHz         in   pixel clock, all logic on posedge
//   btn_rst_n         in   asynchronous active-low reset
//   line              in   one-cycle start-of-line pulse
//   sy                in   signed vertical count
//   cpu_req/we/addr/wdata in  CPU memory request
//   cpu_gnt           out  CPU access accepted this cycle (combinational)
//   cpu_rvalid/rdata  out  registered CPU read return
//   mem_addr/we/wdata out  memory port (combinational mux)
//   mem_rdata         in   memory read data, MEM_LAT cycles after mem_addr
//   vga_counter       out  index+1 of the word on data_from_mem_vga, 0 = idle
//   data_from_mem_vga out  coordinate word to the sprite renderer
//   fetch_busy        out  fetch in progress (issue through last word)
//   fetch_done        out  pulse alongside the last presented word
//   overrun           out  sticky: trigger seen while busy
// ---------------------------------------------------------------------------
module vga_coord_fetch #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] COORD_BASE = 'hFF00,
    parameter int                NUM_WORDS  = 6,
    parameter int                MEM_LAT    = 1,
    parameter int                FETCH_LINE = 480
) (
    input  logic                clk_25MHz,
    input  logic                btn_rst_n,
    input  logic                line,
    input  logic signed [15:0]  sy,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [2:0]          vga_counter,
    output logic [DATA_W-1:0]   data_from_mem_vga,
    output logic                fetch_busy,
    output logic                fetch_done,
    output logic                overrun
);

    localparam logic [2:0]         LAST_IDX = 3'(NUM_WORDS - 1);
    localparam logic [2:0]         WORDS_3  = 3'(NUM_WORDS);
    localparam logic signed [15:0] FETCH_SY = 16'(FETCH_LINE);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic        trigger;
    logic        issuing;
    logic        rd_push;

    // Read tags travel alongside the memory latency so the returning data
    // can be routed to the right consumer.
    logic [MEM_LAT-1:0] tag_valid;
    logic [MEM_LAT-1:0] tag_vga;
    logic [2:0]         tag_idx [MEM_LAT];

    // Port arbitration: the loader wins outright while issuing; at all other
    // times (including DRAIN) the CPU drives the port directly.
    always_comb begin
        trigger    = line && (sy == FETCH_SY);
        issuing    = (state == ISSUE);
        fetch_busy = (state != IDLE);
        cpu_gnt    = cpu_req && !issuing;
        mem_addr   = issuing ? (COORD_BASE + ADDR_W'(idx)) : cpu_addr;
        mem_we     = !issuing && cpu_req && cpu_we;
        mem_wdata  = issuing ? '0 : cpu_wdata;
        rd_push    = issuing || (cpu_gnt && !cpu_we);
        fetch_done = (vga_counter == WORDS_3);
    end

    // Fetch sequencer. DRAIN ends on the cycle the last word is on the
    // outputs, so fetch_busy covers exactly the span of the fetch. A trigger
    // during that span is dropped and only flagged.
    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= ISSUE;
                        idx   <= '0;
                    end
                end
                ISSUE: begin
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                DRAIN: begin
                    if (vga_counter == WORDS_3) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (trigger && fetch_busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Tag shift register, one stage per cycle of memory latency. Writes and
    // idle cycles push an invalid tag.
    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            tag_valid <= '0;
            tag_vga   <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            tag_valid[0] <= rd_push;
            tag_vga[0]   <= issuing;
            tag_idx[0]   <= idx;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_vga[i]   <= tag_vga[i-1];
                tag_idx[i]   <= tag_idx[i-1];
            end
        end
    end

    // Output register: route returning data by the tail tag. Data outputs
    // hold their last value; the strobes drop back to zero every cycle.
    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            vga_counter       <= '0;
            data_from_mem_vga <= '0;
            cpu_rvalid        <= 1'b0;
            cpu_rdata         <= '0;
        end else begin
            vga_counter <= '0;
            cpu_rvalid  <= 1'b0;
            if (tag_valid[MEM_LAT-1]) begin
                if (tag_vga[MEM_LAT-1]) begin
                    vga_counter       <= tag_idx[MEM_LAT-1] + 3'd1;
                    data_from_mem_vga <= mem_rdata;
                end else begin
                    cpu_rvalid <= 1'b1;
                    cpu_rdata  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_coord_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_coord_fetch
//
// Directed bench for vga_coord_fetch. Two instances share all stimulus:
// dut1 with MEM_LAT=1 and dut3 with MEM_LAT=3, each with its own read
// pipeline over one shared memory image. Expected values are written out
// by hand relative to the trigger cycle T.
// ---------------------------------------------------------------------------
module tb_vga_coord_fetch;

    logic               clk_25MHz = 1'b0;
    logic               btn_rst_n;
    logic               line;
    logic signed [15:0] sy;
    logic               cpu_req;
    logic               cpu_we;
    logic [15:0]        cpu_addr;
    logic [15:0]        cpu_wdata;

    logic        cpu_gnt1, cpu_rvalid1, mem_we1, fetch_busy1, fetch_done1, overrun1;
    logic [15:0] cpu_rdata1, mem_addr1, mem_wdata1, mem_rdata1, data1;
    logic [2:0]  vga_counter1;

    logic        cpu_gnt3, cpu_rvalid3, mem_we3, fetch_busy3, fetch_done3, overrun3;
    logic [15:0] cpu_rdata3, mem_addr3, mem_wdata3, mem_rdata3, data3;
    logic [2:0]  vga_counter3;

    logic [15:0] mem [0:65535];
    logic [15:0] pipe3 [0:2];
    logic [15:0] coord_words [0:5] = '{16'd100, 16'd100, 16'd200, 16'd200, 16'd300, 16'd300};

    int   checks   = 0;
    int   failures = 0;
    logic exp_ovr  = 1'b0;

    always #5 clk_25MHz = ~clk_25MHz;

    vga_coord_fetch #(.MEM_LAT(1)) dut1 (
        .clk_25MHz(clk_25MHz), .btn_rst_n(btn_rst_n), .line(line), .sy(sy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .vga_counter(vga_counter1), .data_from_mem_vga(data1),
        .fetch_busy(fetch_busy1), .fetch_done(fetch_done1), .overrun(overrun1)
    );

    vga_coord_fetch #(.MEM_LAT(3)) dut3 (
        .clk_25MHz(clk_25MHz), .btn_rst_n(btn_rst_n), .line(line), .sy(sy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
        .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .vga_counter(vga_counter3), .data_from_mem_vga(data3),
        .fetch_busy(fetch_busy3), .fetch_done(fetch_done3), .overrun(overrun3)
    );

    // Memory read models: data appears MEM_LAT cycles after the address.
    always @(posedge clk_25MHz) begin
        mem_rdata1 <= mem[mem_addr1];
        pipe3[0]   <= mem[mem_addr3];
        pipe3[1]   <= pipe3[0];
        pipe3[2]   <= pipe3[1];
    end
    assign mem_rdata3 = pipe3[2];

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the shared input bus.
    task automatic apply_stimulus(input logic l, input logic signed [15:0] y,
                                  input logic req, input logic we, input logic [15:0] addr);
        line     = l;
        sy       = y;
        cpu_req  = req;
        cpu_we   = we;
        cpu_addr = addr;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk_25MHz);
        #1;
    endtask

    // Trigger a fetch in cycle T, then check cycles T+1..T+11 on both DUTs.
    task automatic run_fetch(input string name, input bit contend, input bit ovr_at4);
        logic [2:0] e_vc1, e_vc3;
        apply_stimulus(1'b1, 16'sd480, 1'b0, 1'b0, 16'h0000);
        next_cycle();
        apply_stimulus(1'b0, 16'sd481, 1'b0, 1'b0, 16'h0000);
        for (int c = 1; c <= 11; c++) begin
            if (contend && c == 1) apply_stimulus(1'b0, 16'sd481, 1'b1, 1'b0, 16'h0010);
            if (contend && c == 8) cpu_req = 1'b0;
            if (ovr_at4 && c == 4) begin line = 1'b1; sy = 16'sd480; end
            if (ovr_at4 && c == 5) begin line = 1'b0; sy = 16'sd481; exp_ovr = 1'b1; end
            #1;
            e_vc1 = (c >= 3 && c <= 8)  ? 3'(c - 2) : 3'd0;
            e_vc3 = (c >= 5 && c <= 10) ? 3'(c - 4) : 3'd0;
            if (c <= 6) begin
                check_output($sformatf("%s addr1 T+%0d", name, c), 32'(mem_addr1), 32'hFF00 + 32'(c - 1));
                check_output($sformatf("%s addr3 T+%0d", name, c), 32'(mem_addr3), 32'hFF00 + 32'(c - 1));
                check_output($sformatf("%s we1 T+%0d", name, c), 32'(mem_we1), 32'd0);
                check_output($sformatf("%s wdata3 T+%0d", name, c), 32'(mem_wdata3), 32'd0);
            end
            check_output($sformatf("%s vc1 T+%0d", name, c), 32'(vga_counter1), 32'(e_vc1));
            check_output($sformatf("%s vc3 T+%0d", name, c), 32'(vga_counter3), 32'(e_vc3));
            if (e_vc1 != 3'd0)
                check_output($sformatf("%s data1 T+%0d", name, c), 32'(data1), 32'(coord_words[e_vc1 - 3'd1]));
            if (e_vc3 != 3'd0)
                check_output($sformatf("%s data3 T+%0d", name, c), 32'(data3), 32'(coord_words[e_vc3 - 3'd1]));
            check_output($sformatf("%s done1 T+%0d", name, c), 32'(fetch_done1), 32'(c == 8));
            check_output($sformatf("%s done3 T+%0d", name, c), 32'(fetch_done3), 32'(c == 10));
            check_output($sformatf("%s busy1 T+%0d", name, c), 32'(fetch_busy1), 32'(c <= 8));
            check_output($sformatf("%s busy3 T+%0d", name, c), 32'(fetch_busy3), 32'(c <= 10));
            check_output($sformatf("%s ovr1 T+%0d", name, c), 32'(overrun1), 32'(exp_ovr));
            check_output($sformatf("%s ovr3 T+%0d", name, c), 32'(overrun3), 32'(exp_ovr));
            if (contend) begin
                check_output($sformatf("%s gnt1 T+%0d", name, c), 32'(cpu_gnt1), 32'(c == 7));
                check_output($sformatf("%s gnt3 T+%0d", name, c), 32'(cpu_gnt3), 32'(c == 7));
                check_output($sformatf("%s rvalid1 T+%0d", name, c), 32'(cpu_rvalid1), 32'(c == 9));
                check_output($sformatf("%s rvalid3 T+%0d", name, c), 32'(cpu_rvalid3), 32'(c == 11));
                if (c == 9)  check_output($sformatf("%s rdata1", name), 32'(cpu_rdata1), 32'h1234);
                if (c == 11) check_output($sformatf("%s rdata3", name), 32'(cpu_rdata3), 32'h1234);
            end else begin
                check_output($sformatf("%s rvalid1 T+%0d", name, c), 32'(cpu_rvalid1), 32'd0);
            end
            next_cycle();
        end
        check_output($sformatf("%s busy1 end", name), 32'(fetch_busy1), 32'd0);
        check_output($sformatf("%s busy3 end", name), 32'(fetch_busy3), 32'd0);
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

    // Directed sequence: reset, fetch, contention, overrun, reset mid-fetch.
    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int k = 0; k < 6; k++) mem[16'hFF00 + k] = coord_words[k];
        mem[16'h0010] = 16'h1234;
        pipe3[0] = '0; pipe3[1] = '0; pipe3[2] = '0;
        mem_rdata1 = '0;
        cpu_wdata = 16'hBEEF;
        btn_rst_n = 1'b0;
        apply_stimulus(1'b0, 16'sd0, 1'b0, 1'b0, 16'h0000);

        for (int r = 0; r < 4; r++) begin
            logic rq, wr;
            rq = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            apply_stimulus(1'($urandom_range(0, 1)), 16'($urandom), rq, wr, 16'($urandom));
            #1;
            check_output("reset vc1", 32'(vga_counter1), 32'd0);
            check_output("reset rvalid1", 32'(cpu_rvalid1), 32'd0);
            check_output("reset busy1", 32'(fetch_busy1), 32'd0);
            check_output("reset ovr1", 32'(overrun1), 32'd0);
            check_output("reset gnt1", 32'(cpu_gnt1), 32'(rq));
            check_output("reset we1", 32'(mem_we1), 32'(rq & wr));
            check_output("reset addr1", 32'(mem_addr1), 32'(cpu_addr));
            check_output("reset vc3", 32'(vga_counter3), 32'd0);
            next_cycle();
        end
        apply_stimulus(1'b0, 16'sd0, 1'b0, 1'b0, 16'h0000);
        btn_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();

        run_fetch("fetch", 1'b0, 1'b0);
        run_fetch("contend", 1'b1, 1'b0);
        run_fetch("overrun", 1'b0, 1'b1);

        // Reset asserted during T+4 of a running fetch.
        apply_stimulus(1'b1, 16'sd480, 1'b0, 1'b0, 16'h0000);
        next_cycle();
        apply_stimulus(1'b0, 16'sd481, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) next_cycle();
        #1;
        check_output("midrst vc1 before", 32'(vga_counter1), 32'd2);
        check_output("midrst ovr1 sticky", 32'(overrun1), 32'd1);
        btn_rst_n = 1'b0;
        #1;
        check_output("midrst vc1", 32'(vga_counter1), 32'd0);
        check_output("midrst busy1", 32'(fetch_busy1), 32'd0);
        check_output("midrst ovr1", 32'(overrun1), 32'd0);
        check_output("midrst busy3", 32'(fetch_busy3), 32'd0);
        btn_rst_n = 1'b1;
        exp_ovr = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            next_cycle();
            check_output($sformatf("midrst vc1 T+%0d", c), 32'(vga_counter1), 32'd0);
            check_output($sformatf("midrst vc3 T+%0d", c), 32'(vga_counter3), 32'd0);
            check_output($sformatf("midrst busy1 T+%0d", c), 32'(fetch_busy1), 32'd0);
        end
        run_fetch("refetch", 1'b0, 1'b0);

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
